// File: rtl/esc_quad_pwm.sv
// Four-channel ESC PWM generator with a shared frame counter.
// Speed updates are staged in a shadow bank and applied only at frame start.
module esc_quad_pwm #(
  parameter int unsigned PERIOD_W  = 20,
  parameter int unsigned MIN_PULSE = 6250,
  parameter int unsigned SCALE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frm_start,
  output logic        upd_pend
);

  localparam int unsigned SPD_W = 11;
  localparam int unsigned N_CH  = 4;
  localparam logic [PERIOD_W-1:0] MIN_W   = PERIOD_W'(MIN_PULSE);
  localparam logic [PERIOD_W-1:0] SCALE_W = PERIOD_W'(SCALE);
  localparam logic [PERIOD_W-1:0] ONE_W   = PERIOD_W'(1);

  logic [PERIOD_W-1:0]                cnt;
  logic [N_CH-1:0][SPD_W-1:0]         spd_in;
  logic [N_CH-1:0][SPD_W-1:0]         shadow;
  logic [N_CH-1:0][SPD_W-1:0]         active;
  logic [N_CH-1:0][PERIOD_W-1:0]      width_c;
  logic [N_CH-1:0]                    pwm;
  logic                               frm_edge_c;

  // Channel order: 0 front, 1 back, 2 left, 3 right
  assign spd_in     = {rght_spd, lft_spd, bck_spd, frnt_spd};
  assign frm_edge_c = (cnt == '0);

  // Free-running frame counter, shadow capture and frame-boundary transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shadow    <= '0;
      active    <= '0;
      frm_start <= 1'b0;
      upd_pend  <= 1'b0;
    end else begin
      cnt       <= cnt + ONE_W;
      frm_start <= frm_edge_c;
      if (frm_edge_c) begin
        active   <= shadow;
        upd_pend <= 1'b0;
      end
      // A strobe coincident with frame start wins the pending flag
      if (vld) begin
        shadow   <= spd_in;
        upd_pend <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign width_c[g] = MIN_W + PERIOD_W'(active[g]) * SCALE_W;

    // Rise at frame start, fall when the counter reaches this channel's width
    always_ff @(posedge clk) begin
      if (rst) begin
        pwm[g] <= 1'b0;
      end else if (frm_edge_c) begin
        pwm[g] <= 1'b1;
      end else if (cnt == width_c[g]) begin
        pwm[g] <= 1'b0;
      end
    end
  end

  assign frnt_pwm = pwm[0];
  assign bck_pwm  = pwm[1];
  assign lft_pwm  = pwm[2];
  assign rght_pwm = pwm[3];

endmodule
